// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared constants for the fetch PC sequencer: state encodings, default vectors
// and the instruction-alignment mask.
package fetch_pc_sequencer_pkg;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;
  localparam logic [31:0] ALIGN_MASK     = 32'h0000_0003;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr & ALIGN_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/fetch_pc_sequencer_pc_incrementer.sv
// 32-bit +4 incrementer, wraps mod 2^32; shared by pc_plus_four and the sequential update.
module pc_incrementer (
  input  logic [31:0] pc_in,
  output logic [31:0] pc_out
);

  assign pc_out = pc_in + 32'd4;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC sequencer: holds through stalls, buffers a stalled redirect,
// traps misaligned targets. Optional DELAY_SLOT_EN keeps the delay-slot fetch (no flush).
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = RESET_PC_DEF,
  parameter logic [31:0] EXCEPTION_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_fetch,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_address,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_four,
  output logic        fetch_valid,
  output logic        flush_decode,
  output logic        addr_error
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        err_q, err_d;
  logic        apply;
  logic [31:0] target;
  logic [31:0] pc_inc;

  pc_incrementer u_inc (
    .pc_in  (pc_q),
    .pc_out (pc_inc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    err_d   = err_q;
    apply   = 1'b0;
    target  = redirect_address;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (stall_fetch) begin
          if (redirect_valid) begin
            pend_d  = redirect_address;
            state_d = ST_PEND;
          end
        end else if (redirect_valid) begin
          apply = 1'b1;
        end else begin
          pc_d = pc_inc;
        end
      end
      ST_PEND: begin
        if (stall_fetch) begin
          if (redirect_valid) pend_d = redirect_address;
        end else begin
          // a fresh redirect in the applying cycle supersedes the buffered one
          apply   = 1'b1;
          target  = redirect_valid ? redirect_address : pend_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    if (apply) begin
      if (is_aligned(target)) begin
        pc_d = target;
      end else begin
        pc_d  = EXCEPTION_VECTOR;
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus_four = pc_inc;
  assign fetch_valid  = (state_q != ST_BOOT);
  assign addr_error   = err_q;

`ifdef DELAY_SLOT_EN
  assign flush_decode = 1'b0;
`else
  assign flush_decode = apply;
`endif

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Randomized + directed bench for fetch_pc_sequencer against a cycle-level behavioural model.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_fetch = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_address = 32'h0;
  logic [31:0] pc, pc_plus_four;
  logic        fetch_valid, flush_decode, addr_error;

  int n_chk = 0;
  int n_err = 0;

  // behavioural model
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_pend_v;
  logic [31:0] m_pend;
  logic        m_err;

  always #5 clk = ~clk;

  fetch_pc_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .stall_fetch      (stall_fetch),
    .redirect_valid   (redirect_valid),
    .redirect_address (redirect_address),
    .pc               (pc),
    .pc_plus_four     (pc_plus_four),
    .fetch_valid      (fetch_valid),
    .flush_decode     (flush_decode),
    .addr_error       (addr_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_flush();
`ifdef DELAY_SLOT_EN
    return 1'b0;
`else
    return !m_boot && !stall_fetch && (redirect_valid || m_pend_v);
`endif
  endfunction

  function automatic void model_edge();
    logic [31:0] tgt;
    if (reset) begin
      m_pc = 32'h0; m_boot = 1'b1; m_pend_v = 1'b0; m_err = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (stall_fetch) begin
      if (redirect_valid) begin
        m_pend = redirect_address;
        m_pend_v = 1'b1;
      end
    end else if (redirect_valid || m_pend_v) begin
      tgt = redirect_valid ? redirect_address : m_pend;
      if (tgt % 4 == 0) m_pc = tgt;
      else begin
        m_pc = 32'h8000_0180;
        m_err = 1'b1;
      end
      m_pend_v = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endfunction

  task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] ra);
    @(negedge clk);
    reset = rst; stall_fetch = st; redirect_valid = rv; redirect_address = ra;
    #1;
    check("pc", pc, m_pc);
    check("pc_plus_four", pc_plus_four, m_pc + 32'd4);
    check("fetch_valid", {31'h0, fetch_valid}, {31'h0, !m_boot});
    check("flush_decode", {31'h0, flush_decode}, {31'h0, exp_flush()});
    check("addr_error", {31'h0, addr_error}, {31'h0, m_err});
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    m_pc = 32'h0; m_boot = 1'b1; m_pend_v = 1'b0; m_pend = 32'h0; m_err = 1'b0;
    @(posedge clk);
    model_edge();
    step(1, 0, 0, 32'h0);
    #2 check("reset_pc", pc, 32'h0);
    check("reset_fv", {31'h0, fetch_valid}, 32'h0);

    // boot then free run, redirect to 0x40 at pc 0x10
    step(0, 0, 0, 32'h0);
    repeat (4) step(0, 0, 0, 32'h0);
    #2 check("pc_before_redir", pc, 32'h10);
    step(0, 0, 1, 32'h40);
    #2 check("redir_0x40", pc, 32'h40);

    // stalled redirect held three cycles then applied
    step(0, 1, 1, 32'h100);
    step(0, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    #2 check("stall_hold", pc, 32'h40);
    step(0, 0, 0, 32'h0);
    #2 check("pending_0x100", pc, 32'h100);

    // newest pending wins
    step(0, 1, 1, 32'h100);
    step(0, 1, 1, 32'h200);
    step(0, 0, 0, 32'h0);
    #2 check("pending_0x200", pc, 32'h200);

    // misaligned target traps, error sticky until reset
    step(0, 0, 1, 32'h42);
    #2 check("trap_vec", pc, 32'h8000_0180);
    step(0, 0, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    #2 check("err_sticky", {31'h0, addr_error}, 32'h1);
    step(1, 0, 0, 32'h0);
    #2 check("err_cleared", {31'h0, addr_error}, 32'h0);

    // wrap at top of address space
    step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'hFFFF_FFFC);
    #2 check("wrap_ppf", pc_plus_four, 32'h0);
    step(0, 0, 0, 32'h0);
    #2 check("wrap_pc", pc, 32'h0);

    // reset while pending drops the target
    step(0, 1, 1, 32'h500);
    step(1, 1, 0, 32'h0);
    #2 check("rst_pend_pc", pc, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    #2 check("rst_pend_drop", pc, 32'h4);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 9) < 8) a = a & 32'hFFFF_FFFC;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 3, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
